// File: rtl/lc3_imem_pkg.sv
// Shared types and constants for the LC3 instruction-memory responder.
package lc3_imem_pkg;

  typedef logic [15:0] lc3_word_t;

  localparam lc3_word_t   NOP_INSTR = 16'h0000;
  localparam int unsigned LAT_MAX   = 4;

  typedef struct packed {
    logic      valid;
    lc3_word_t pc;
    logic      oob;
  } imem_req_t;

  // True when any address bit at or above the index width is set.
  function automatic logic addr_oob(lc3_word_t addr, int unsigned aw);
    return (aw < 16) && ((addr >> aw) != '0);
  endfunction

endpackage

// File: rtl/lc3_imem_ram.sv
// DEPTH x 16 program memory: registered read port (first latency stage), independent write port.
module lc3_imem_ram
  import lc3_imem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  input  logic          rd_oob,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  lc3_word_t     wr_data,
  output lc3_word_t     rd_data
);

  lc3_word_t mem [DEPTH];
  lc3_word_t rd_data_q;

  // Array is deliberately not reset; program contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Non-blocking update gives read-before-write on a same-edge collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rd_oob ? NOP_INSTR : mem[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/lc3_imem_responder.sv
// Instruction-memory responder: returns the word at pc RD_LAT cycles after each fetch strobe.
module lc3_imem_responder
  import lc3_imem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  lc3_word_t pc,
  input  logic      instrmem_rd,
  input  logic      ld_en,
  input  lc3_word_t ld_addr,
  input  lc3_word_t ld_data,
  output lc3_word_t imem_dout,
  output logic      imem_valid,
  output lc3_word_t imem_pc,
  output logic      imem_oob,
  output lc3_word_t rd_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic      rd_oob;
  logic      ld_oob;
  lc3_word_t ram_data;
  imem_req_t req0_q;
  imem_req_t out_req;
  lc3_word_t out_data;
  lc3_word_t rd_count_q;

  assign rd_oob = addr_oob(pc, AW);
  assign ld_oob = addr_oob(ld_addr, AW);

  lc3_imem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (instrmem_rd),
    .rd_idx  (pc[AW-1:0]),
    .rd_oob  (rd_oob),
    .wr_en   (ld_en && !ld_oob),
    .wr_idx  (ld_addr[AW-1:0]),
    .wr_data (ld_data),
    .rd_data (ram_data)
  );

  // Request tag travelling alongside the RAM's read register.
  always_ff @(posedge clock) begin
    if (reset) begin
      req0_q <= '0;
    end else begin
      req0_q.valid <= instrmem_rd;
      if (instrmem_rd) begin
        req0_q.pc  <= pc;
        req0_q.oob <= rd_oob;
      end
    end
  end

  // Payloads only advance behind a valid bit, so the last stage holds the previous response.
  if (RD_LAT == 1) begin : g_no_pipe
    assign out_req  = req0_q;
    assign out_data = ram_data;
  end else begin : g_pipe
    imem_req_t req_q  [RD_LAT-1];
    lc3_word_t data_q [RD_LAT-1];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < int'(RD_LAT) - 1; i++) begin
          req_q[i]  <= '0;
          data_q[i] <= '0;
        end
      end else begin
        req_q[0].valid <= req0_q.valid;
        if (req0_q.valid) begin
          req_q[0].pc  <= req0_q.pc;
          req_q[0].oob <= req0_q.oob;
          data_q[0]    <= ram_data;
        end
        for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
          req_q[i].valid <= req_q[i-1].valid;
          if (req_q[i-1].valid) begin
            req_q[i].pc  <= req_q[i-1].pc;
            req_q[i].oob <= req_q[i-1].oob;
            data_q[i]    <= data_q[i-1];
          end
        end
      end
    end

    assign out_req  = req_q[RD_LAT-2];
    assign out_data = data_q[RD_LAT-2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count_q <= '0;
    end else if (instrmem_rd && (rd_count_q != 16'hFFFF)) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign imem_dout  = out_data;
  assign imem_valid = out_req.valid;
  assign imem_pc    = out_req.pc;
  assign imem_oob   = out_req.oob;
  assign rd_count   = rd_count_q;

endmodule

// File: tb/tb_lc3_imem_responder.sv
// Self-checking bench: three responder configurations driven in parallel against a cycle model.
module tb_lc3_imem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = '0;
  logic        instrmem_rd = 1'b0;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic [15:0] dout_w  [3];
  logic        valid_w [3];
  logic [15:0] pc_w    [3];
  logic        oob_w   [3];
  logic [15:0] cnt_w   [3];

  always #5 clock = ~clock;

  lc3_imem_responder #(.DEPTH(65536), .RD_LAT(1)) u_a (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .imem_dout(dout_w[0]), .imem_valid(valid_w[0]),
    .imem_pc(pc_w[0]), .imem_oob(oob_w[0]), .rd_count(cnt_w[0])
  );
  lc3_imem_responder #(.DEPTH(256), .RD_LAT(3)) u_b (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .imem_dout(dout_w[1]), .imem_valid(valid_w[1]),
    .imem_pc(pc_w[1]), .imem_oob(oob_w[1]), .rd_count(cnt_w[1])
  );
  lc3_imem_responder #(.DEPTH(256), .RD_LAT(2)) u_c (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .imem_dout(dout_w[2]), .imem_valid(valid_w[2]),
    .imem_pc(pc_w[2]), .imem_oob(oob_w[2]), .rd_count(cnt_w[2])
  );

  // Reference model: request history per edge, plus the memory image each config should hold.
  typedef struct {
    bit          v;
    logic [15:0] pc;
    logic [15:0] w;
    bit          oob;
  } req_t;

  req_t        ring [3][8];
  logic [15:0] mem_a [65536];
  logic [15:0] mem_s [256];
  logic        exp_v [3];
  logic [15:0] exp_d [3];
  logic [15:0] exp_pc [3];
  logic        exp_oob [3];
  logic [15:0] exp_cnt [3];
  int          last_rst [3] = '{-100, -100, -100};
  int          edge_n = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int depth_of(int d);
    return (d == 0) ? 65536 : 256;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      req_t r;
      int   k;
      r.v   = instrmem_rd && !reset;
      r.pc  = pc;
      r.oob = (int'(pc) >= depth_of(d));
      r.w   = r.oob ? 16'h0000 : ((d == 0) ? mem_a[pc] : mem_s[pc[7:0]]);
      ring[d][edge_n % 8] = r;
      if (reset) begin
        exp_v[d] = 0; exp_d[d] = '0; exp_pc[d] = '0; exp_oob[d] = 0; exp_cnt[d] = '0;
        last_rst[d] = edge_n;
      end else begin
        k = edge_n - lat_of(d) + 1;
        if (k >= 0 && k > last_rst[d] && ring[d][k % 8].v) begin
          exp_v[d]   = 1;
          exp_d[d]   = ring[d][k % 8].w;
          exp_pc[d]  = ring[d][k % 8].pc;
          exp_oob[d] = ring[d][k % 8].oob;
        end else begin
          exp_v[d] = 0;
        end
        if (instrmem_rd && exp_cnt[d] != 16'hFFFF) exp_cnt[d] = exp_cnt[d] + 16'd1;
      end
    end
    if (ld_en) begin
      mem_a[ld_addr] = ld_data;
      if (ld_addr < 16'd256) mem_s[ld_addr[7:0]] = ld_data;
    end
    edge_n++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("u%0d valid", d), 16'(valid_w[d]), 16'(exp_v[d]));
      check($sformatf("u%0d dout", d), dout_w[d], exp_d[d]);
      check($sformatf("u%0d pc", d), pc_w[d], exp_pc[d]);
      check($sformatf("u%0d oob", d), 16'(oob_w[d]), 16'(exp_oob[d]));
      check($sformatf("u%0d count", d), cnt_w[d], exp_cnt[d]);
    end
  endtask

  task automatic step(input bit chk);
    @(posedge clock);
    model_edge();
    #1;
    if (chk) check_all();
  endtask

  logic [15:0] words [4] = '{16'h1021, 16'h5020, 16'h0E01, 16'hF025};
  logic [15:0] saved;
  bit          vpat [5] = '{0, 0, 1, 0, 0};

  initial begin
    // Reset
    reset = 1;
    step(1); step(1);
    reset = 0;
    step(1);
    check("reset count", cnt_w[0], 16'h0000);

    // Preload 0..511 with random words, then the program at 0x3000
    for (int i = 0; i < 512; i++) begin
      ld_en = 1; ld_addr = 16'(i); ld_data = 16'($urandom);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      ld_addr = 16'h3000 + 16'(i); ld_data = words[i];
      step(1);
    end
    ld_en = 0;

    // Four back-to-back reads at latency 1
    for (int i = 0; i < 4; i++) begin
      instrmem_rd = 1; pc = 16'h3000 + 16'(i);
      step(1);
      check("t1 valid", 16'(valid_w[0]), 16'h0001);
      check("t1 dout", dout_w[0], words[i]);
      check("t1 pc", pc_w[0], 16'h3000 + 16'(i));
    end
    instrmem_rd = 0;
    step(1);
    check("t1 idle valid", 16'(valid_w[0]), 16'h0000);
    check("t1 count", cnt_w[0], 16'h0004);

    // Single read at latency 3
    ld_en = 1; ld_addr = 16'h0005; ld_data = 16'hABCD;
    step(1);
    ld_en = 0; instrmem_rd = 1; pc = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      step(1);
      instrmem_rd = 0;
      check("t2 valid", 16'(valid_w[1]), 16'(vpat[i]));
      if (i >= 2) check("t2 dout", dout_w[1], 16'hABCD);
    end

    // Out-of-range then last in-range address
    instrmem_rd = 1; pc = 16'h0100;
    step(1);
    pc = 16'h00FF;
    step(1);
    instrmem_rd = 0;
    step(1);
    check("t3 oob dout", dout_w[1], 16'h0000);
    check("t3 oob flag", 16'(oob_w[1]), 16'h0001);
    step(1);
    check("t3 ff dout", dout_w[1], mem_s[8'hFF]);
    check("t3 ff flag", 16'(oob_w[1]), 16'h0000);

    // Read-before-write collision
    ld_en = 1; ld_addr = 16'h0010; ld_data = 16'h2222;
    step(1);
    ld_data = 16'h1111; instrmem_rd = 1; pc = 16'h0010;
    step(1);
    check("t4 old word", dout_w[0], 16'h2222);
    ld_en = 0;
    step(1);
    check("t4 new word", dout_w[0], 16'h1111);
    instrmem_rd = 0;
    step(1); step(1); step(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      instrmem_rd = 1'($urandom);
      pc          = 16'($urandom_range(0, 511));
      ld_en       = ($urandom_range(0, 3) == 0);
      ld_addr     = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom_range(0, 511));
      ld_data     = 16'($urandom);
      step(1);
    end
    reset = 0; instrmem_rd = 0; ld_en = 0;
    step(1); step(1); step(1);

    // Reset mid-stream at latency 2
    saved = mem_s[8'h20];
    instrmem_rd = 1; pc = 16'h0020;
    step(1);
    pc = 16'h0021;
    step(1);
    pc = 16'h0022; reset = 1;
    step(1);
    reset = 0; instrmem_rd = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t5 valid", 16'(valid_w[2]), 16'h0000);
      check("t5 dout", dout_w[2], 16'h0000);
      check("t5 pc", pc_w[2], 16'h0000);
      check("t5 count", cnt_w[2], 16'h0000);
    end
    instrmem_rd = 1; pc = 16'h0020;
    step(1);
    instrmem_rd = 0;
    step(1);
    check("t5 mem valid", 16'(valid_w[2]), 16'h0001);
    check("t5 mem intact", dout_w[2], saved);

    // Saturating request counter
    reset = 1;
    step(1);
    reset = 0; instrmem_rd = 1; pc = 16'h0000;
    for (int i = 0; i < 32'hFFFE; i++) step(0);
    instrmem_rd = 0;
    step(1);
    check("t6 count fffe", cnt_w[0], 16'hFFFE);
    instrmem_rd = 1;
    step(1); step(1); step(1);
    instrmem_rd = 0;
    step(1);
    check("t6 count sat a", cnt_w[0], 16'hFFFF);
    check("t6 count sat b", cnt_w[1], 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
